genius_fluxo_dados_param: RTL
=============================

Name: genius_fluxo_dados_param

Overview:
- Parametrised data path for the Genius memory game; N-button generalisation of the fixed 4-button/16-step design.
- Holds the sequence in a writable register-array memory, so rounds can be extended with the player's own move ("grava" mode).
- Contains the address and round counters, the move register, edge detection, a saturating timeout counter and the LED source selector.
- Driven by the game control unit. All control inputs are synchronous and active-high.

Parameters:
- NUM_BOTOES, 4, number of buttons/LEDs; width of the move and data words (min 2).
- DEPTH, 16, sequence length; AW = clog2(DEPTH) (min 2, power of two).
- TIMEOUT, 5000, clock cycles allowed per move; counter width = clog2(TIMEOUT).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- zeraE  in  1  clear address counter.
- contaE  in  1  increment address counter.
- zeraR  in  1  clear round counter.
- contaR  in  1  increment round counter.
- limpaJ  in  1  clear move register.
- registraJ  in  1  load botoes into move register.
- grava  in  1  write move register into mem[endereco].
- zeraT  in  1  clear timeout counter.
- contaT  in  1  enable timeout counting.
- registraLeds  in  1  load led_sel into selector register.
- led_sel  in  1  1 = LEDs/memory address follow round; 0 = follow move/address.
- botoes  in  NUM_BOTOES  raw button levels.
- jogada_correta  out  1  mem data == move register.
- enderecoIgualRodada  out  1  address == round.
- fimE  out  1  address == DEPTH-1.
- fimR  out  1  round == DEPTH-1.
- jogada_feita  out  1  one-cycle pulse on a button press.
- timeout  out  1  timeout reached.
- leds  out  NUM_BOTOES  LED drive.
- db_tem_jogada  out  1  any button currently pressed.
- db_endereco, db_rodada  out  AW  counter values.
- db_memoria, db_jogada  out  NUM_BOTOES  memory data / move register.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - both counters, the move register, the selector register, the edge register and the timeout counter;
  - memory: entry i = one-hot bit (i mod NUM_BOTOES).
  - Resulting outputs: jogada_feita=0, timeout=0, fimE=fimR=0, enderecoIgualRodada=1, leds=0.
- Counters (address, round):
  - Modulo DEPTH; DEPTH-1 wraps to 0 on conta.
  - zera has priority over conta in the same cycle.
  - fimE/fimR are combinational from the count.
- Move register: limpaJ has priority over registraJ.
- Memory read address:
  - Read address = round if the selector register is 1, else address.
  - Read is registered: db_memoria reflects the address of the previous cycle (1-cycle latency).
  - jogada_correta is combinational on the registered data vs the move register.
- Memory write:
  - grava=1 writes the move register into mem[address] at the clock edge.
  - Read of the same address in that cycle returns the new data (write-first).
  - grava together with registraJ writes the OLD move register value.
- Press detection:
  - sinal = OR of botoes; edge register samples sinal every cycle.
  - jogada_feita = sinal & ~edge_reg, exactly one cycle per press.
  - Holding a button gives no repeat.
  - A button held across reset release pulses on the first cycle after release.
- Timeout counter:
  - Increments when contaT=1 and below TIMEOUT-1; saturates at TIMEOUT-1.
  - Cleared by zeraT, or by jogada_feita in the same cycle (clear has priority).
  - timeout = (count == TIMEOUT-1), held as a level until cleared.
- LED output: leds = selector ? db_memoria : db_jogada; db_tem_jogada = sinal.

Optional Feature:
- Macro: GENIUS_VALIDA_JOGADA_EN.
- With the macro:
  - jogada_feita fires only when botoes is exactly one-hot at the rising edge of sinal.
  - A multi-button edge drives a one-cycle pulse on an extra output jogada_invalida.
  - registraJ is ignored while botoes is not one-hot.
- Without the macro: any nonzero edge counts; jogada_invalida is absent.

Test Plan:
1. Reset, then read address 0..5 with led_sel=0 -> db_memoria = 0001,0010,0100,1000,0001,0010, each 1 cycle after the address update.
2. contaE for 16 cycles -> fimE high at count 15, wraps to 0. zeraE+contaE together -> count 0.
3. botoes=0100 held 10 cycles -> jogada_feita high exactly 1 cycle. registraJ then grava at address 3 -> mem[3]=0100 and jogada_correta=1 next cycle.
4. TIMEOUT=8, contaT held -> timeout rises on cycle 7 and stays high. A press then -> timeout low the next cycle.
5. Selector: registraLeds with led_sel=1, round=2 -> leds=0100. led_sel=0 with move 1000 -> leds=1000.
6. Reset asserted mid-count (address=9, timeout count=5) -> all zero immediately, without waiting for a clock edge.
7. With GENIUS_VALIDA_JOGADA_EN: botoes=0110 -> jogada_invalida pulses 1 cycle, jogada_feita=0, move register unchanged.

Source files
------------

// File: rtl/genius_fluxo_dados_param.sv
// Purpose: parametrised Genius data path (counters, sequence memory, move register, press edge, timeout, LED select).
// Latency: counters/registers update on the clock edge; memory read is registered (1 cycle); status outputs are combinational.
// Backpressure: none; driven by the control unit every cycle. Optional macro GENIUS_VALIDA_JOGADA_EN adds one-hot move validation.
module genius_fluxo_dados_param #(
    parameter int NUM_BOTOES = 4,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 5000,
    localparam int AW        = $clog2(DEPTH),
    localparam int TW        = $clog2(TIMEOUT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  zeraE,
    input  logic                  contaE,
    input  logic                  zeraR,
    input  logic                  contaR,
    input  logic                  limpaJ,
    input  logic                  registraJ,
    input  logic                  grava,
    input  logic                  zeraT,
    input  logic                  contaT,
    input  logic                  registraLeds,
    input  logic                  led_sel,
    input  logic [NUM_BOTOES-1:0] botoes,
    output logic                  jogada_correta,
    output logic                  enderecoIgualRodada,
    output logic                  fimE,
    output logic                  fimR,
    output logic                  jogada_feita,
`ifdef GENIUS_VALIDA_JOGADA_EN
    output logic                  jogada_invalida,
`endif
    output logic                  timeout,
    output logic [NUM_BOTOES-1:0] leds,
    output logic                  db_tem_jogada,
    output logic [AW-1:0]         db_endereco,
    output logic [AW-1:0]         db_rodada,
    output logic [NUM_BOTOES-1:0] db_memoria,
    output logic [NUM_BOTOES-1:0] db_jogada
);

    localparam logic [AW-1:0] ULTIMO = AW'(DEPTH - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT - 1);

    logic [AW-1:0]         endereco_q, endereco_d;
    logic [AW-1:0]         rodada_q, rodada_d;
    logic [NUM_BOTOES-1:0] jogada_q, jogada_d;
    logic                  sel_q, sel_d;
    logic                  borda_q;
    logic [TW-1:0]         tempo_q, tempo_d;
    logic [NUM_BOTOES-1:0] mem_q [DEPTH];
    logic [NUM_BOTOES-1:0] mem_dat_q, mem_dat_d;
    logic [AW-1:0]         rd_addr;
    logic                  sinal;
    logic                  subida;
    logic                  carrega_j;

    // Press detection: any button raises sinal; a press is the cycle sinal rises.
    // Gating with reset keeps the pulse quiet while reset is held, so a button held
    // across release fires on the first cycle after release (edge register is 0).
    assign sinal  = |botoes;
    assign subida = reset & sinal & ~borda_q;

`ifdef GENIUS_VALIDA_JOGADA_EN
    logic um_quente;
    assign um_quente       = sinal && ((botoes & (botoes - NUM_BOTOES'(1))) == '0);
    assign jogada_feita    = subida & um_quente;
    assign jogada_invalida = subida & ~um_quente;
    assign carrega_j       = registraJ & um_quente;
`else
    assign jogada_feita    = subida;
    assign carrega_j       = registraJ;
`endif

    // Next state for counters, move register, selector and timeout counter.
    always_comb begin
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        sel_d      = sel_q;
        tempo_d    = tempo_q;

        if (zeraE)       endereco_d = '0;
        else if (contaE) endereco_d = (endereco_q == ULTIMO) ? '0 : endereco_q + AW'(1);

        if (zeraR)       rodada_d = '0;
        else if (contaR) rodada_d = (rodada_q == ULTIMO) ? '0 : rodada_q + AW'(1);

        if (limpaJ)         jogada_d = '0;
        else if (carrega_j) jogada_d = botoes;

        if (registraLeds) sel_d = led_sel;

        // A press restarts the move timer, so it shares the clear path with zeraT.
        if (zeraT || jogada_feita)          tempo_d = '0;
        else if (contaT && tempo_q != T_MAX) tempo_d = tempo_q + TW'(1);
    end

    // Registered memory read; a write to the address being read is forwarded (write-first).
    assign rd_addr   = sel_q ? rodada_q : endereco_q;
    assign mem_dat_d = (grava && (endereco_q == rd_addr)) ? jogada_q : mem_q[rd_addr];

    // Control/state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco_q <= '0;
            rodada_q   <= '0;
            jogada_q   <= '0;
            sel_q      <= 1'b0;
            borda_q    <= 1'b0;
            tempo_q    <= '0;
            mem_dat_q  <= '0;
        end else begin
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            jogada_q   <= jogada_d;
            sel_q      <= sel_d;
            borda_q    <= sinal;
            tempo_q    <= tempo_d;
            mem_dat_q  <= mem_dat_d;
        end
    end

    // Sequence memory: reset loads a rotating one-hot pattern; grava stores the current (old) move.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NUM_BOTOES'(1) << (i % NUM_BOTOES);
            end
        end else if (grava) begin
            mem_q[endereco_q] <= jogada_q;
        end
    end

    assign jogada_correta      = (mem_dat_q == jogada_q);
    assign enderecoIgualRodada = (endereco_q == rodada_q);
    assign fimE                = (endereco_q == ULTIMO);
    assign fimR                = (rodada_q == ULTIMO);
    assign timeout             = (tempo_q == T_MAX);
    assign leds                = sel_q ? mem_dat_q : jogada_q;
    assign db_tem_jogada       = sinal;
    assign db_endereco         = endereco_q;
    assign db_rodada           = rodada_q;
    assign db_memoria          = mem_dat_q;
    assign db_jogada           = jogada_q;

endmodule
